// File: rtl/mcc_pkg.sv
// Shared definitions for the multi-cycle sequencing controller:
// state codes, opcode values and datapath select encodings.
package mcc_pkg;

  // State type, used for debug views and by anything that wants a named state.
  typedef enum logic [2:0] {
    MCC_IF  = 3'd0,
    MCC_ID  = 3'd1,
    MCC_EX  = 3'd2,
    MCC_MEM = 3'd3,
    MCC_WB  = 3'd4
  } mcc_state_e;

  // Plain constants used by the FSM itself.
  localparam logic [2:0] S_IF  = 3'd0;
  localparam logic [2:0] S_ID  = 3'd1;
  localparam logic [2:0] S_EX  = 3'd2;
  localparam logic [2:0] S_MEM = 3'd3;
  localparam logic [2:0] S_WB  = 3'd4;

  // Opcodes, IR[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  // PC source select.
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  // True for every opcode the controller knows how to sequence.
  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multi_cycle_control_if.sv
// Controller <-> datapath signal bundle.
// Handshake: the controller holds MemRead_o/MemWrite_o (and IorD_o) steady
// until MemAck_i is seen high in the same cycle; that cycle completes the
// access, there is no separate ready phase and MemAck_i outside a request
// carries no meaning.
// The master modport is the controller, the slave modport is the datapath.
interface multi_cycle_control_if;
  import mcc_pkg::*;

  logic [5:0] Op_i;
  logic       Zero_i;
  logic       MemAck_i;
  logic       PCWrite_o;
  logic [1:0] PCSrc_o;
  logic       IRWrite_o;
  logic       IorD_o;
  logic       MemRead_o;
  logic       MemWrite_o;
  logic       RegDst_o;
  logic       ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [1:0] ALUOp_o;
  logic       MemtoReg_o;
  logic       RegWrite_o;
  logic       Illegal_o;
  logic [2:0] State_o;

  modport master (
    input  Op_i, Zero_i, MemAck_i,
    output PCWrite_o, PCSrc_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o,
    output RegDst_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, MemtoReg_o, RegWrite_o,
    output Illegal_o, State_o
  );

  modport slave (
    output Op_i, Zero_i, MemAck_i,
    input  PCWrite_o, PCSrc_o, IRWrite_o, IorD_o, MemRead_o, MemWrite_o,
    input  RegDst_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o, MemtoReg_o, RegWrite_o,
    input  Illegal_o, State_o
  );

endinterface

// File: rtl/mcc_perf_counters.sv
// Free-running cycle counter and retired-instruction counter.
// Both wrap at 2^CNT_WIDTH and clear on reset.
module mcc_perf_counters #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 instr_done_i,
  output logic [CNT_WIDTH-1:0] CycleCnt_o,
  output logic [CNT_WIDTH-1:0] InstrCnt_o
);

  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] instr_q, instr_d;

  // Next counts: cycles always advance, instructions on each return to fetch.
  always_comb begin
    cycle_d = cycle_q + 1'b1;
    instr_d = instr_q;
    if (instr_done_i) instr_d = instr_q + 1'b1;
  end

  // Counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign CycleCnt_o = cycle_q;
  assign InstrCnt_o = instr_q;

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU sequencing FSM: IF -> ID -> EX -> MEM -> WB as the
// instruction class needs, driving every datapath enable and select and
// stalling in IF/MEM until the memory acknowledges.
// Optional build macro MCC_PERF_COUNTERS_EN adds cycle/instruction counters
// (CycleCnt_o, InstrCnt_o) of width CNT_WIDTH.
module multi_cycle_control
  import mcc_pkg::*;
`ifdef MCC_PERF_COUNTERS_EN
#(
  parameter int CNT_WIDTH = 32
)
`endif
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  multi_cycle_control_if.master bus
`ifdef MCC_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0]  CycleCnt_o,
  output logic [CNT_WIDTH-1:0]  InstrCnt_o
`endif
);

  logic [2:0] state_q, state_d;
  logic [5:0] op_q, op_d;

  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_dst;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;

  // Opcode is captured while in ID; EX/MEM/WB decode from the captured copy
  // so the IR may change underneath without disturbing the sequence.
  always_comb begin
    op_d = op_q;
    if (state_q == S_ID) op_d = bus.Op_i;
  end

  // Next state and all datapath controls, decoded from the current state.
  always_comb begin
    state_d    = S_IF;
    pc_write   = 1'b0;
    pc_src     = PCSRC_SEQ;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = ALUB_RT;
    alu_op     = ALUOP_ADD;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IF: begin
        // Fetch from PC while PC+4 is formed in the ALU.
        mem_read  = 1'b1;
        alu_src_b = ALUB_FOUR;
        if (bus.MemAck_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end else begin
          state_d  = S_IF;
        end
      end
      S_ID: begin
        // Branch target is computed speculatively for every opcode.
        alu_src_b = ALUB_IMM_SH;
        if (bus.Op_i == OP_J) begin
          pc_write = 1'b1;
          pc_src   = PCSRC_JUMP;
          state_d  = S_IF;
        end else if (op_is_legal(bus.Op_i)) begin
          state_d  = S_EX;
        end else begin
          illegal  = 1'b1;
          state_d  = S_IF;
        end
      end
      S_EX: begin
        alu_src_a = 1'b1;
        case (op_q)
          OP_RTYPE: begin
            alu_src_b = ALUB_RT;
            alu_op    = ALUOP_FUNCT;
            state_d   = S_WB;
          end
          OP_ADDI: begin
            alu_src_b = ALUB_IMM;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = ALUB_IMM;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_src_b = ALUB_RT;
            alu_op    = ALUOP_SUB;
            pc_write  = bus.Zero_i;
            pc_src    = PCSRC_BRANCH;
            state_d   = S_IF;
          end
          default: begin
            alu_src_a = 1'b0;
            state_d   = S_IF;
          end
        endcase
      end
      S_MEM: begin
        // Request is held steady until acknowledged.
        iord      = 1'b1;
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if ((op_q != OP_LW) && (op_q != OP_SW)) begin
          iord    = 1'b0;
          state_d = S_IF;
        end else if (bus.MemAck_i) begin
          state_d = (op_q == OP_LW) ? S_WB : S_IF;
        end else begin
          state_d = S_MEM;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
        state_d    = S_IF;
      end
      default: begin
        // Unused codes fall back to fetch with everything deasserted.
        state_d = S_IF;
      end
    endcase
  end

  // State and captured-opcode registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IF;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  assign bus.PCWrite_o  = pc_write;
  assign bus.PCSrc_o    = pc_src;
  assign bus.IRWrite_o  = ir_write;
  assign bus.IorD_o     = iord;
  assign bus.MemRead_o  = mem_read;
  assign bus.MemWrite_o = mem_write;
  assign bus.RegDst_o   = reg_dst;
  assign bus.ALUSrcA_o  = alu_src_a;
  assign bus.ALUSrcB_o  = alu_src_b;
  assign bus.ALUOp_o    = alu_op;
  assign bus.MemtoReg_o = mem_to_reg;
  assign bus.RegWrite_o = reg_write;
  assign bus.Illegal_o  = illegal;
  assign bus.State_o    = state_q;

`ifdef MCC_PERF_COUNTERS_EN
  logic instr_done;

  // An instruction retires whenever the FSM leaves ID/EX/MEM/WB for IF.
  always_comb begin
    instr_done = 1'b0;
    if ((state_q == S_ID || state_q == S_EX || state_q == S_MEM ||
         state_q == S_WB) && (state_d == S_IF))
      instr_done = 1'b1;
  end

  mcc_perf_counters #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_perf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .instr_done_i (instr_done),
    .CycleCnt_o   (CycleCnt_o),
    .InstrCnt_o   (InstrCnt_o)
  );
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed instruction table,
// reset-abort sequence, randomized instruction stream, optional counters.
module tb_multi_cycle_control;

  localparam logic [5:0] RT = 6'b000000, ADDI = 6'b001000, LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011, BEQ = 6'b000100, JMP = 6'b000010;

  logic clk;
  logic rst_i;
  int   n_checks;
  int   n_errors;

  multi_cycle_control_if bus();

`ifdef MCC_PERF_COUNTERS_EN
  logic [3:0] cycle_cnt;
  logic [3:0] instr_cnt;
  multi_cycle_control #(.CNT_WIDTH(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .bus        (bus),
    .CycleCnt_o (cycle_cnt),
    .InstrCnt_o (instr_cnt)
  );
`else
  multi_cycle_control dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );
`endif

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed output vector:
  // {State, PCWrite, PCSrc, IRWrite, IorD, MemRead, MemWrite, RegDst,
  //  ALUSrcA, ALUSrcB, ALUOp, MemtoReg, RegWrite, Illegal}
  logic [18:0] act_vec;
  assign act_vec = {bus.State_o, bus.PCWrite_o, bus.PCSrc_o, bus.IRWrite_o,
                    bus.IorD_o, bus.MemRead_o, bus.MemWrite_o, bus.RegDst_o,
                    bus.ALUSrcA_o, bus.ALUSrcB_o, bus.ALUOp_o, bus.MemtoReg_o,
                    bus.RegWrite_o, bus.Illegal_o};

  function automatic logic [18:0] pk(
    input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
    input logic irw, input logic iord, input logic mr, input logic mw,
    input logic rd, input logic sa, input logic [1:0] sb,
    input logic [1:0] aop, input logic m2r, input logic rw, input logic ill);
    return {st, pcw, pcs, irw, iord, mr, mw, rd, sa, sb, aop, m2r, rw, ill};
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return (op == RT) || (op == ADDI) || (op == LW) || (op == SW) ||
           (op == BEQ) || (op == JMP);
  endfunction

  // Zero-wait latency per instruction class, plus one cycle per wait.
  function automatic int lat(input logic [5:0] op, input int ifw, input int memw);
    int base;
    case (op)
      RT:      base = 4;
      ADDI:    base = 4;
      LW:      base = 5;
      SW:      base = 4;
      BEQ:     base = 3;
      default: base = 2;
    endcase
    return base + ifw + (((op == LW) || (op == SW)) ? memw : 0);
  endfunction

  // scoreboard: per-cycle stimulus with expected outputs
  typedef struct packed {
    logic [5:0]  op;
    logic        zero;
    logic        ack;
    logic [18:0] exp;
  } vec_t;
  vec_t vq[$];

  task automatic check_vec(input string name, input logic [18:0] a, input logic [18:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, a, e);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_checks++;
    if (a != e) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic push(input logic [5:0] op, input logic zero, input logic ack,
                      input logic [18:0] e);
    vec_t v;
    v.op = op; v.zero = zero; v.ack = ack; v.exp = e;
    vq.push_back(v);
  endtask

  function automatic logic [18:0] if_wait_vec();
    return pk(3'd0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0);
  endfunction

  // Reference model: expand one instruction into its cycle-by-cycle
  // stimulus and required outputs. Op_i is garbage except in ID, Zero_i
  // garbage except in EX of beq, MemAck_i garbage outside IF/MEM.
  task automatic gen_instr(input logic [5:0] op, input logic zero,
                           input int ifw, input int memw);
    logic is_mem;
    is_mem = (op == LW) || (op == SW);
    for (int i = 0; i < ifw; i++)
      push(6'($urandom), 1'($urandom), 1'b0, if_wait_vec());
    push(6'($urandom), 1'($urandom), 1'b1,
         pk(3'd0, 1, 2'b00, 1, 0, 1, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0));
    if (op == JMP)
      push(op, 1'($urandom), 1'($urandom),
           pk(3'd1, 1, 2'b10, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 0));
    else
      push(op, 1'($urandom), 1'($urandom),
           pk(3'd1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, !legal(op)));
    if (!legal(op) || op == JMP) return;
    case (op)
      RT:   push(6'($urandom), 1'($urandom), 1'($urandom),
                 pk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 0, 0, 0));
      BEQ:  push(6'($urandom), zero, 1'($urandom),
                 pk(3'd2, zero, 2'b01, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 0));
      default: push(6'($urandom), 1'($urandom), 1'($urandom),
                 pk(3'd2, 0, 2'b00, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0));
    endcase
    if (is_mem) begin
      for (int i = 0; i <= memw; i++)
        push(6'($urandom), 1'($urandom), (i == memw),
             pk(3'd3, 0, 2'b00, 0, 1, op == LW, op == SW, 0, 0, 2'b00, 2'b00, 0, 0, 0));
    end
    if (op == RT || op == ADDI || op == LW)
      push(6'($urandom), 1'($urandom), 1'($urandom),
           pk(3'd4, 0, 2'b00, 0, 0, 0, 0, op == RT, 0, 2'b00, 2'b00, op == LW, 1, 0));
  endtask

  // driver: run one instruction, check every cycle, measure latency from DUT
  task automatic run_instr(input string tag, input logic [5:0] op, input logic zero,
                           input int ifw, input int memw);
    vec_t v;
    int   cyc;
    bit   seen_nz;
    bit   done;
    vq.delete();
    gen_instr(op, zero, ifw, memw);
    cyc = 0; seen_nz = 0; done = 0;
    while (!done && cyc < 60) begin
      cyc++;
      @(posedge clk); #1;
      if (vq.size() > 0) v = vq.pop_front();
      else begin
        v.op = 6'($urandom); v.zero = 1'($urandom); v.ack = 1'b0;
        v.exp = if_wait_vec();
      end
      bus.Op_i = v.op; bus.Zero_i = v.zero; bus.MemAck_i = v.ack;
      #1;
      check_vec($sformatf("%s_c%0d", tag, cyc), act_vec, v.exp);
      if (bus.MemRead_o && bus.MemWrite_o) check_int({tag, "_rd_wr_excl"}, 1, 0);
      if (bus.State_o != 3'd0) seen_nz = 1;
      else if (seen_nz) begin
        done = 1;
        check_int({tag, "_latency"}, cyc - 1, lat(op, ifw, memw));
      end
    end
    if (!done) check_int({tag, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [5:0] op;
    logic       zero;
    int         ifw;
    int         memw;
  } dir_t;
  dir_t dir_tab[9];

  initial begin
    logic [5:0] rop;
    int k;
    n_checks = 0;
    n_errors = 0;
    // directed table: {opcode, Zero_i, IF waits, MEM waits}
    dir_tab[0] = '{RT,   1'b0, 0, 0};
    dir_tab[1] = '{LW,   1'b0, 0, 3};
    dir_tab[2] = '{BEQ,  1'b1, 0, 0};
    dir_tab[3] = '{BEQ,  1'b0, 0, 0};
    dir_tab[4] = '{6'b111111, 1'b0, 0, 0};
    dir_tab[5] = '{ADDI, 1'b0, 2, 0};
    dir_tab[6] = '{SW,   1'b0, 1, 2};
    dir_tab[7] = '{JMP,  1'b0, 1, 0};
    dir_tab[8] = '{LW,   1'b1, 0, 0};

    // reset
    rst_i = 1'b0;
    bus.Op_i = 6'b101010; bus.Zero_i = 1'b0; bus.MemAck_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_vec("reset_hold", act_vec, if_wait_vec());
    rst_i = 1'b1;
    #1 check_vec("reset_release", act_vec, if_wait_vec());

    for (int i = 0; i < 9; i++)
      run_instr($sformatf("dir%0d", i), dir_tab[i].op, dir_tab[i].zero,
                dir_tab[i].ifw, dir_tab[i].memw);

    // reset in the middle of an R-type EX
    @(posedge clk); #1 bus.MemAck_i = 1'b1;
    #1 check_int("abort_if_state", int'(bus.State_o), 0);
    @(posedge clk); #1 bus.Op_i = RT; bus.MemAck_i = 1'b0;
    #1 check_int("abort_id_state", int'(bus.State_o), 1);
    @(posedge clk); #1 bus.Op_i = 6'b110011;
    #1 check_int("abort_ex_state", int'(bus.State_o), 2);
    #1 rst_i = 1'b0;
    #1 check_vec("abort_async", act_vec, if_wait_vec());
    @(posedge clk); #1 check_int("abort_no_regwrite", int'(bus.RegWrite_o), 0);
    rst_i = 1'b1;
    #1 check_vec("abort_release", act_vec, if_wait_vec());

    // randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 6);
      case (k)
        0: rop = RT;
        1: rop = ADDI;
        2: rop = LW;
        3: rop = SW;
        4: rop = BEQ;
        5: rop = JMP;
        default: begin
          rop = 6'($urandom);
          while (legal(rop)) rop = 6'($urandom);
        end
      endcase
      run_instr($sformatf("rnd%0d", i), rop, 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

`ifdef MCC_PERF_COUNTERS_EN
    // 20 back-to-back jumps, zero-wait memory, 4-bit counters
    @(posedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1;
    check_int("perf_reset_cycle", int'(cycle_cnt), 0);
    check_int("perf_reset_instr", int'(instr_cnt), 0);
    bus.Op_i = JMP; bus.MemAck_i = 1'b1;
    rst_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check_int("perf_cycle_cnt", int'(cycle_cnt), 40 % 16);
    check_int("perf_instr_cnt", int'(instr_cnt), 20 % 16);
    check_int("perf_state", int'(bus.State_o), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
